// File: rtl/microwave_input_conditioner_if.sv
// Raw button/door inputs and the conditioned pulses/levels handed to the microwave controller.
interface microwave_input_conditioner_if;
   logic btnU_raw, btnL_raw, btnC_raw, btnD_raw, door_raw;
   logic btnU, btnL, btnC, btnD, door;

   modport master (
      output btnU_raw, btnL_raw, btnC_raw, btnD_raw, door_raw,
      input  btnU, btnL, btnC, btnD, door
   );

   modport slave (
      input  btnU_raw, btnL_raw, btnC_raw, btnD_raw, door_raw,
      output btnU, btnL, btnC, btnD, door
   );
endinterface

// File: rtl/microwave_input_conditioner.sv
// Input front end: per-channel 2-flop sync, tick-based debounce, press-pulse edge detect,
// optional hold auto-repeat; one shared 1 ms prescaler drives every channel.
module microwave_input_conditioner_chan #(
   parameter int DEBOUNCE_TICKS = 10,
   parameter int REPEAT_DELAY   = 500,
   parameter int REPEAT_PERIOD  = 100,
   parameter bit REPEAT_EN      = 1'b0,
   parameter bit IS_LEVEL       = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick,
   input  logic raw,
   output logic out
);
   localparam logic [1:0]  R_IDLE   = 2'd0;
   localparam logic [1:0]  R_DELAY  = 2'd1;
   localparam logic [1:0]  R_REPEAT = 2'd2;
   localparam logic [7:0]  DB_LAST  = 8'(DEBOUNCE_TICKS - 1);
   localparam logic [15:0] DLY_LAST = 16'(REPEAT_DELAY - 1);
   localparam logic [15:0] PER_LAST = 16'(REPEAT_PERIOD - 1);

   logic [1:0]  sync_q, sync_d;
   logic        db_q, db_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [1:0]  st_q, st_d;
   logic [15:0] hcnt_q, hcnt_d;
   logic        out_q, out_d;
   logic        rise, rep;

   always_comb begin
      sync_d = {sync_q[0], raw};
      db_d   = db_q;
      cnt_d  = cnt_q;
      if (sync_q[1] == db_q) begin
         cnt_d = '0;
      end else if (tick) begin
         if (cnt_q == DB_LAST) begin
            db_d  = sync_q[1];
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end
      rise = db_d & ~db_q;
   end

   // Release wins over a repeat landing on the same tick, so no pulse on the falling cycle.
   always_comb begin
      st_d   = st_q;
      hcnt_d = hcnt_q;
      rep    = 1'b0;
      if (!db_d) begin
         st_d   = R_IDLE;
         hcnt_d = '0;
      end else begin
         case (st_q)
            R_IDLE: begin
               if (rise) begin
                  st_d   = R_DELAY;
                  hcnt_d = '0;
               end
            end
            R_DELAY: begin
               if (tick) begin
                  if (hcnt_q == DLY_LAST) begin
                     rep    = 1'b1;
                     hcnt_d = '0;
                     st_d   = R_REPEAT;
                  end else begin
                     hcnt_d = hcnt_q + 16'd1;
                  end
               end
            end
            R_REPEAT: begin
               if (tick) begin
                  if (hcnt_q == PER_LAST) begin
                     rep    = 1'b1;
                     hcnt_d = '0;
                  end else begin
                     hcnt_d = hcnt_q + 16'd1;
                  end
               end
            end
            default: begin
               st_d   = R_IDLE;
               hcnt_d = '0;
            end
         endcase
      end
      out_d = IS_LEVEL ? db_q : (rise | (REPEAT_EN & rep));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         db_q   <= 1'b0;
         cnt_q  <= '0;
         st_q   <= R_IDLE;
         hcnt_q <= '0;
         out_q  <= 1'b0;
      end else begin
         sync_q <= sync_d;
         db_q   <= db_d;
         cnt_q  <= cnt_d;
         st_q   <= st_d;
         hcnt_q <= hcnt_d;
         out_q  <= out_d;
      end
   end

   assign out = out_q;
endmodule

module microwave_input_conditioner #(
   parameter int TICK_DIV       = 100000,
   parameter int DEBOUNCE_TICKS = 10,
   parameter int REPEAT_DELAY   = 500,
   parameter int REPEAT_PERIOD  = 100
) (
   input  logic                           clk,
   input  logic                           reset,
   microwave_input_conditioner_if.slave   io
);
   localparam int NUM_LANES = 5;
   localparam int PW        = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0]        pre_q, pre_d;
   logic                 tick;
   logic [NUM_LANES-1:0] raw, cond;

   // Lane order: 0=U, 1=L, 2=C, 3=D, 4=door.
   assign raw = {io.door_raw, io.btnD_raw, io.btnC_raw, io.btnL_raw, io.btnU_raw};

   always_comb begin
      tick  = (pre_q == PRE_LAST);
      pre_d = tick ? '0 : pre_q + PW'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) pre_q <= '0;
      else        pre_q <= pre_d;
   end

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      microwave_input_conditioner_chan #(
         .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
         .REPEAT_DELAY   (REPEAT_DELAY),
         .REPEAT_PERIOD  (REPEAT_PERIOD),
         .REPEAT_EN      (i == 0 || i == 3),
         .IS_LEVEL       (i == 4)
      ) u_chan (
         .clk   (clk),
         .rst_n (reset),
         .tick  (tick),
         .raw   (raw[i]),
         .out   (cond[i])
      );
   end

   assign io.btnU = cond[0];
   assign io.btnL = cond[1];
   assign io.btnC = cond[2];
   assign io.btnD = cond[3];
   assign io.door = cond[4];
endmodule

// File: tb/tb_microwave_input_conditioner.sv
// Scoreboarded bench: directed stimulus pushes expected output events (mask + cycle), a monitor pops them.
module tb_microwave_input_conditioner;
   localparam int TICK_DIV = 10, DEBOUNCE_TICKS = 3, REPEAT_DELAY = 4, REPEAT_PERIOD = 2;
   localparam logic [4:0] MU = 5'b00001, ML = 5'b00010, MC = 5'b00100, MD = 5'b01000, MDOOR = 5'b10000;

   typedef struct {
      logic [4:0] mask;
      int         cyc;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic door_prev = 1'b0;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;
   exp_t sb_q[$];

   microwave_input_conditioner_if io ();

   microwave_input_conditioner #(
      .TICK_DIV(TICK_DIV), .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
      .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .io    (io)
   );

   always #5 clk = ~clk;

   // Edges since the last reset release; tick-updates land on multiples of TICK_DIV.
   always @(posedge clk or negedge reset) begin
      if (!reset) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic push_exp(input logic [4:0] m, input int c);
      exp_t e;
      e.mask = m;
      e.cyc  = c;
      sb_q.push_back(e);
   endtask

   task automatic at(input int t);
      while (cyc < t) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [4:0] outs();
      return {io.door, io.btnD, io.btnC, io.btnL, io.btnU};
   endfunction

   // Monitor: each cycle with a button pulse or a door rising edge is one event.
   always @(negedge clk) begin
      logic [4:0] ev;
      exp_t       e;
      ev = {io.door & ~door_prev, io.btnD, io.btnC, io.btnL, io.btnU};
      door_prev = io.door;
      if (ev != 5'b0) begin
         tests++;
         if (sb_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event: mask %b at cycle %0d, expected no event", ev, cyc);
         end else begin
            e = sb_q.pop_front();
            if (ev !== e.mask || cyc != e.cyc) begin
               fails++;
               $display("FAIL event: mask %b at cycle %0d, expected mask %b at cycle %0d",
                        ev, cyc, e.mask, e.cyc);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit hit, expected bench completion");
      $fatal(1);
   end

   initial begin
      io.btnU_raw = 1'b0; io.btnL_raw = 1'b0; io.btnC_raw = 1'b0;
      io.btnD_raw = 1'b0; io.door_raw = 1'b0;
      #1 reset = 1'b0;
      #2 check("reset_outputs", outs(), 5'b0);
      repeat (3) @(posedge clk);
      #1 check("reset_hold", outs(), 5'b0);
      reset = 1'b1;

      // Clean press: one pulse three ticks after the press, none on release.
      at(10);  io.btnC_raw = 1'b1; push_exp(MC, 40);
      at(110); io.btnC_raw = 1'b0;

      // Bounce: 7-cycle toggling never survives three ticks; stable hold flips at tick 280.
      push_exp(ML, 280);
      for (int c = 0; c < 60; c++) begin
         at(200 + c);
         io.btnL_raw = ((c / 7) % 2 == 0);
      end
      at(320); io.btnL_raw = 1'b0;

      // Auto-repeat on U; L held alongside pulses once only. Release at 600 cancels the 630 repeat.
      at(400); io.btnU_raw = 1'b1; io.btnL_raw = 1'b1;
      push_exp(MU | ML, 430);
      push_exp(MU, 470);
      for (int k = 0; k < 7; k++) push_exp(MU, 490 + 20 * k);
      at(600); io.btnU_raw = 1'b0; io.btnL_raw = 1'b0;

      // Simultaneous U/D; release drops db exactly on the tick where the first repeat would fire.
      at(700); io.btnU_raw = 1'b1; io.btnD_raw = 1'b1; push_exp(MU | MD, 730);
      at(740); io.btnU_raw = 1'b0; io.btnD_raw = 1'b0;

      // Door opens; a 15-cycle glitch closed cannot accumulate three ticks.
      at(800); io.door_raw = 1'b1; push_exp(MDOOR, 831);
      at(900); io.door_raw = 1'b0;
      at(915); io.door_raw = 1'b1;
      at(950); check("door_after_glitch", io.door, 1'b1);

      // Reset while D is repeating and the door is open.
      at(1000); io.btnD_raw = 1'b1;
      push_exp(MD, 1030); push_exp(MD, 1070); push_exp(MD, 1090);
      at(1090);
      #5 check("btnD_pulse_before_reset", io.btnD, 1'b1);
      reset = 1'b0;
      #1 check("reset_mid_repeat", outs(), 5'b0);
      repeat (4) @(posedge clk);
      #1 check("reset_held_outputs", outs(), 5'b0);
      check("reset_no_pending", sb_q.size(), 0);

      // Inputs still active at release: fresh press, door-open event, repeat restarts from delay.
      push_exp(MD, 30); push_exp(MDOOR, 31);
      push_exp(MD, 70); push_exp(MD, 90); push_exp(MD, 110);
      reset = 1'b1;
      at(100); io.btnD_raw = 1'b0;
      at(160); io.door_raw = 1'b0;
      at(200);
      check("door_closed", io.door, 1'b0);
      check("scoreboard_drained", sb_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
